// File: rtl/cpu_pkg.sv
// Shared constants and hazard-cause encoding for the moxie register scoreboard.
package cpu_pkg;

  localparam int NREGS        = 16;
  localparam int REG_IDX_W    = $clog2(NREGS);
  localparam int MAX_INFLIGHT = 3;
  localparam int INFL_W       = 4;

  typedef enum logic [2:0] {
    HZ_NONE  = 3'd0,
    HZ_RAW_A = 3'd1,
    HZ_RAW_B = 3'd2,
    HZ_WAW   = 3'd3,
    HZ_FULL  = 3'd4,
    HZ_EXT   = 3'd5
  } hazard_e;

  // External stall dominates, then the register hazards in operand order.
  function automatic hazard_e hazard_cause(input logic ext, input logic raw_a,
                                           input logic raw_b, input logic waw,
                                           input logic full);
    if (ext)        return HZ_EXT;
    else if (raw_a) return HZ_RAW_A;
    else if (raw_b) return HZ_RAW_B;
    else if (waw)   return HZ_WAW;
    else if (full)  return HZ_FULL;
    else            return HZ_NONE;
  endfunction

endpackage

// File: rtl/cpu_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones.
// One-cycle update latency; synchronous clear wins over enable.
module cpu_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_scoreboard.sv
// Register-hazard scoreboard: zero-cycle RAW/WAW/full/ext stall, registered pending map.
// Decode is held via stall_o; a retiring register unblocks its reader one cycle later.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS        = cpu_pkg::NREGS,
  parameter int MAX_INFLIGHT = cpu_pkg::MAX_INFLIGHT,
  parameter int CNT_W        = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic                     rd_a_en_i,
  input  logic [$clog2(NREGS)-1:0] rd_a_idx_i,
  input  logic                     rd_b_en_i,
  input  logic [$clog2(NREGS)-1:0] rd_b_idx_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(NREGS)-1:0] wr_idx_i,
  input  logic                     wb_en_i,
  input  logic [$clog2(NREGS)-1:0] wb_idx_i,
  input  logic                     flush_i,
  input  logic                     ext_stall_i,
  output logic                     stall_o,
  output logic                     issue_o,
  output logic [NREGS-1:0]         pending_o,
  output logic [INFL_W-1:0]        inflight_o,
  output logic                     error_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  logic [NREGS-1:0]  pending_q, pending_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              error_q, error_d;
  logic              raw_a, raw_b, waw, full;
  logic              stall, issue, wr_issue, wb_hit, wb_miss;

  // Hazards look only at registered state: no bypass of a same-cycle retire.
  assign raw_a = rd_a_en_i & pending_q[rd_a_idx_i];
  assign raw_b = rd_b_en_i & pending_q[rd_b_idx_i];
  assign waw   = wr_en_i & pending_q[wr_idx_i];
  assign full  = wr_en_i & (inflight_q == INFL_W'(MAX_INFLIGHT));

  assign stall    = rst_i | ext_stall_i | (valid_i & (raw_a | raw_b | waw | full));
  assign issue    = valid_i & ~stall & ~flush_i;
  assign wr_issue = issue & wr_en_i;
  assign wb_hit   = wb_en_i & pending_q[wb_idx_i];
  assign wb_miss  = wb_en_i & ~pending_q[wb_idx_i];

  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
    error_d    = error_q;
    if (flush_i) begin
      pending_d  = '0;
      inflight_d = '0;
    end else begin
      if (wr_issue) pending_d[wr_idx_i] = 1'b1;
      if (wb_hit)   pending_d[wb_idx_i] = 1'b0;
      if (wb_miss)  error_d = 1'b1;
      unique case ({wr_issue, wb_hit})
        2'b10:   inflight_d = inflight_q + INFL_W'(1);
        2'b01:   inflight_d = inflight_q - INFL_W'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      inflight_q <= '0;
      error_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
    end
  end

  cpu_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (valid_i & stall & ~rst_i),
    .cnt_o (stall_cnt_o)
  );

  assign stall_o    = stall;
  assign issue_o    = issue;
  assign pending_o  = pending_q;
  assign inflight_o = inflight_q;
  assign error_o    = error_q;

  a_inflight_max: assert property (@(posedge clk_i) disable iff (rst_i)
                                   inflight_q <= INFL_W'(MAX_INFLIGHT));
  a_popcount:     assert property (@(posedge clk_i) disable iff (rst_i)
                                   $countones(pending_q) == int'(inflight_q));

endmodule
